icache: RTL and testbench

Read-only, direct-mapped instruction cache between the hart's instruction fetch port and the boot ROM (flash). It serves 32-bit instruction words from 64-byte lines and, on a miss, fetches a full 512-bit line from external memory in a single transfer. There is no write path and no coherence: instruction memory is treated as immutable.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_store.sv | 54 +++++
 rtl/icache.sv | 102 ++++++++++
 tb/tb_icache.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, geometry helpers and FSM states for icache
package icache_pkg;

  localparam int LINE_BITS      = 512;
  localparam int WORD_BITS      = 32;
  localparam int OFFSET_BITS    = 6;
  localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;

  // Guarded so a single-line cache still gets a legal 1-bit index field
  function automatic int index_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  function automatic int tag_bits(input int lines, input int addr_w);
    return addr_w - OFFSET_BITS - index_bits(lines);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } state_e;

endpackage

// File: rtl/icache_store.sv
// rtl/icache_store.sv - valid/tag/data arrays: sync line write, async hit + word read
module icache_store
  import icache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:2]             rd_addr_i,
  output logic                          hit_o,
  output logic [WORD_BITS-1:0]          rd_word_o,
  input  logic                          wr_en_i,
  input  logic [ADDR_W-1:OFFSET_BITS]   wr_line_addr_i,
  input  logic [LINE_BITS-1:0]          wr_line_i
);

  localparam int INDEX_BITS = index_bits(LINES);
  localparam int TAG_BITS   = tag_bits(LINES, ADDR_W);

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0]             rd_idx;
  logic [INDEX_BITS-1:0]             wr_idx;
  logic [TAG_BITS-1:0]               rd_tag;
  logic [OFFSET_BITS-3:0]            rd_sel;

  assign rd_idx = rd_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign rd_tag = rd_addr_i[ADDR_W-1 -: TAG_BITS];
  assign rd_sel = rd_addr_i[OFFSET_BITS-1:2];
  assign wr_idx = wr_line_addr_i[OFFSET_BITS +: INDEX_BITS];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_word_o = data_q[rd_idx][rd_sel*WORD_BITS +: WORD_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a valid bit
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_line_addr_i[ADDR_W-1 -: TAG_BITS];
      data_q[wr_idx] <= wr_line_i;
    end
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - read-only direct-mapped instruction cache: fetch FSM and request latch
module icache
  import icache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_addr_valid,
  input  logic [ADDR_W-1:0]    cpu_addr,
  output logic                 cpu_data_ready,
  output logic [WORD_BITS-1:0] cpu_data_o,
  output logic                 mem_addr_valid,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_data_ready,
  input  logic [LINE_BITS-1:0] mem_data_i
);

  state_e                 state_q;
  logic [ADDR_W-1:2]      req_addr_q;
  logic                   rdy_q;
  logic [WORD_BITS-1:0]   data_q;
  logic                   mem_valid_q;
  logic [ADDR_W-1:0]      mem_addr_q;

  logic                   hit;
  logic [WORD_BITS-1:0]   hit_word;
  logic [WORD_BITS-1:0]   fill_word;
  logic                   fill_done;
  logic                   unused_byte_bits;

  assign unused_byte_bits = ^cpu_addr[1:0];

  // Install is gated by reset so a fill interrupted by reset leaves no trace
  assign fill_done = (state_q == FILL) && mem_data_ready && !rst;
  assign fill_word = mem_data_i[req_addr_q[OFFSET_BITS-1:2]*WORD_BITS +: WORD_BITS];

  icache_store #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk            (clk),
    .rst            (rst),
    .rd_addr_i      (cpu_addr[ADDR_W-1:2]),
    .hit_o          (hit),
    .rd_word_o      (hit_word),
    .wr_en_i        (fill_done),
    .wr_line_addr_i (req_addr_q[ADDR_W-1:OFFSET_BITS]),
    .wr_line_i      (mem_data_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      rdy_q       <= 1'b0;
      data_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_addr_valid) begin
            if (hit) begin
              data_q  <= hit_word;
              rdy_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {cpu_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
              req_addr_q  <= cpu_addr[ADDR_W-1:2];
              state_q     <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_data_ready) begin
            mem_valid_q <= 1'b0;
            // A withdrawn request still installs the line but gets no response
            if (cpu_addr_valid) begin
              data_q  <= fill_word;
              rdy_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_data_ready = rdy_q;
  assign cpu_data_o     = data_q;
  assign mem_addr_valid = mem_valid_q;
  assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line/tag reference model
module tb_icache;

  logic         clk;
  logic         rst;
  logic         cpu_addr_valid;
  logic [31:0]  cpu_addr;
  logic         cpu_data_ready;
  logic [31:0]  cpu_data_o;
  logic         mem_addr_valid;
  logic [31:0]  mem_addr;
  logic         mem_data_ready;
  logic [511:0] mem_data_i;

  int errors = 0;
  int checks = 0;

  // Reference model: which line address each of the 16 slots currently holds
  bit          m_valid [16];
  logic [25:0] m_line  [16];

  icache #(.LINES(16), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr_valid (cpu_addr_valid),
    .cpu_addr       (cpu_addr),
    .cpu_data_ready (cpu_data_ready),
    .cpu_data_o     (cpu_data_o),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr       (mem_addr),
    .mem_data_ready (mem_data_ready),
    .mem_data_i     (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always_comb begin
    mem_data_i = '0;
    for (int i = 0; i < 16; i++)
      mem_data_i[i*32 +: 32] = rom_word({mem_addr[31:6], 6'b0} + 32'(i * 4));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_addr_valid = 1'b0;
    mem_data_ready = 1'b0;
    tick();
    chk("rst_rdy", 32'(cpu_data_ready), 32'd0);
    chk("rst_data", cpu_data_o, 32'd0);
    chk("rst_mvalid", 32'(mem_addr_valid), 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch; keep leaves cpu_addr_valid high for a back-to-back follow-up
  task automatic fetch(input logic [31:0] a, input int delay, input bit drop, input bit keep);
    int   idx;
    bit   hit;
    logic [31:0] line;
    idx  = int'(a[9:6]);
    line = {a[31:6], 6'b0};
    hit  = m_valid[idx] && (m_line[idx] == a[31:6]);
    cpu_addr = a;
    cpu_addr_valid = 1'b1;
    tick();
    if (hit) begin
      chk("hit_rdy", 32'(cpu_data_ready), 32'd1);
      chk("hit_data", cpu_data_o, rom_word(a & ~32'h3));
      chk("hit_nomem", 32'(mem_addr_valid), 32'd0);
    end else begin
      chk("miss_req", 32'(mem_addr_valid), 32'd1);
      chk("miss_addr", mem_addr, line);
      chk("miss_nordy", 32'(cpu_data_ready), 32'd0);
      if (drop) cpu_addr_valid = 1'b0;
      for (int d = 0; d < delay; d++) begin
        tick();
        chk("fill_hold_v", 32'(mem_addr_valid), 32'd1);
        chk("fill_hold_a", mem_addr, line);
        chk("fill_wait_rdy", 32'(cpu_data_ready), 32'd0);
      end
      mem_data_ready = 1'b1;
      tick();
      mem_data_ready = 1'b0;
      chk("fill_done_v", 32'(mem_addr_valid), 32'd0);
      m_valid[idx] = 1'b1;
      m_line[idx]  = a[31:6];
      if (drop) begin
        chk("drop_nordy", 32'(cpu_data_ready), 32'd0);
      end else begin
        chk("fill_rdy", 32'(cpu_data_ready), 32'd1);
        chk("fill_data", cpu_data_o, rom_word(a & ~32'h3));
      end
    end
    if (!keep) cpu_addr_valid = 1'b0;
    tick();
    chk("pulse_end", 32'(cpu_data_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    cpu_addr_valid = 1'b0;
    cpu_addr = '0;
    mem_data_ready = 1'b0;
    tick();
    do_reset();

    fetch(32'h0000_0004, 0, 0, 0);
    fetch(32'h0000_003C, 0, 0, 0);
    fetch(32'h0000_0400, 1, 0, 0);
    fetch(32'h0000_0000, 0, 0, 0);
    fetch(32'h0000_0040, 5, 0, 0);

    // Level-high memory ready outside a fill must not disturb a hit
    mem_data_ready = 1'b1;
    fetch(32'h0000_0044, 0, 0, 0);
    mem_data_ready = 1'b0;

    cpu_addr = 32'h0000_0080;
    cpu_addr_valid = 1'b1;
    tick();
    chk("rf_req", 32'(mem_addr_valid), 32'd1);
    tick();
    do_reset();
    fetch(32'h0000_0080, 0, 0, 0);
    fetch(32'h0000_0084, 0, 0, 0);

    fetch(32'h0000_1100, 2, 1, 0);
    fetch(32'h0000_1104, 0, 0, 0);

    do_reset();
    fetch(32'h0000_0000, 0, 0, 1);
    fetch(32'h0000_0004, 0, 0, 1);
    fetch(32'h0000_0008, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      a = {20'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      fetch(a, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
